// File: rtl/serial_out_port_pkg.sv
// serial_out_port_pkg: shared state encoding and defaults for the serial output port
package serial_out_port_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int CLK_DIV_DEF    = 4;
    localparam int DEPTH_DEF      = 4;
    localparam int BITS_PER_FRAME = 8;
endpackage

// File: rtl/serial_out_port_sync_fifo.sv
// sync_fifo: single-clock FIFO; a push when full is refused, head is read combinationally
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign full   = r_count == (AW+1)'(DEPTH);
    assign empty  = r_count == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];
    assign count  = r_count;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push && !reset) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/serial_out_port.sv
// serial_out_port: CPU byte FIFO feeding an 8N1 serial transmitter with a registered tx line
module serial_out_port
    import serial_out_port_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   clr_ovf,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   ovf,
    output logic                   tx
);
    localparam int BW = $clog2(CLK_DIV);
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;
    logic          w_pop;
    logic          w_empty;
    logic          w_last;
    logic [7:0]    w_head;
    assign w_pop  = r_state == IDLE && !w_empty;
    assign w_last = r_baud == BW'(CLK_DIV - 1);
    assign busy   = r_state != IDLE || !w_empty;
    assign tx     = r_tx;
    assign ovf    = r_ovf;
    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_head),
        .count (count),
        .full  (full),
        .empty (w_empty)
    );
    // tx follows the state of the previous cycle, so it trails the FSM by one clock
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_tx   <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
            r_ovf  <= (wr_en && full) ? 1'b1 : clr_ovf ? 1'b0 : r_ovf;
            r_baud <= (r_state == IDLE || w_last) ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_shift <= w_head;
                    r_state <= START;
                end
                START: if (w_last) begin
                    r_state <= DATA;
                    r_bit   <= '0;
                end
                DATA: if (w_last) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'(BITS_PER_FRAME - 1)) r_state <= STOP;
                end
                STOP: if (w_last) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
